// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the wait-state data memory (dmem_ws).
// Holds access-size codes, FSM state codes, the wait-counter width and
// the load-extension helper used by the lane datapath.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_WAIT = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   localparam int CNT_W = 3;

   // Access attributes captured at acceptance (address is held separately
   // because its useful width depends on DEPTH).
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] wdata;
   } dmem_op_t;

   // Sign- or zero-extend a byte (is_half=0) or half-word (is_half=1).
   function automatic logic [31:0] ext_load(input logic [15:0] val,
                                            input logic        is_half,
                                            input logic        sext);
      logic fill;
      if (is_half) begin
         fill     = sext & val[15];
         ext_load = {{16{fill}}, val};
      end else begin
         fill     = sext & val[7];
         ext_load = {{24{fill}}, val[7:0]};
      end
   endfunction

endpackage

// File: rtl/dmem_ws_lane.sv
// dmem_lane: combinational lane datapath for dmem_ws.
// From the low address bits and access size it builds the byte-lane write
// mask, the merged store word, the extended load value and a misalign flag.
// Half-words use lanes addr[1]*2..+1, so an odd half address is naturally
// forced down to the aligned half; words ignore addr[1:0] entirely.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_sext,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_old_word,
   output logic [3:0]  o_mask,
   output logic [31:0] o_merged,
   output logic [31:0] o_load,
   output logic        o_misalign
);

   logic [31:0] w_wrep;
   logic [15:0] w_half;
   logic [7:0]  w_byte;

   // Decode the size into lane mask, replicated store data and load value.
   always_comb begin
      o_mask     = 4'b1111;
      w_wrep     = i_wdata;
      o_load     = i_old_word;
      o_misalign = 1'b0;
      w_half     = i_addr_lo[1] ? i_old_word[31:16] : i_old_word[15:0];
      w_byte     = i_old_word[{i_addr_lo, 3'b000} +: 8];
      case (i_size)
         SZ_BYTE: begin
            o_mask = 4'b0001 << i_addr_lo;
            w_wrep = {4{i_wdata[7:0]}};
            o_load = ext_load({8'h00, w_byte}, 1'b0, i_sext);
         end
         SZ_HALF: begin
            o_mask     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            w_wrep     = {2{i_wdata[15:0]}};
            o_load     = ext_load(w_half, 1'b1, i_sext);
            o_misalign = i_addr_lo[0];
         end
         default: begin
            // Word and the reserved encoding behave identically.
            o_mask     = 4'b1111;
            w_wrep     = i_wdata;
            o_load     = i_old_word;
            o_misalign = (i_addr_lo != 2'b00);
         end
      endcase
   end

   // Merge new lanes into the old word under the write mask.
   always_comb begin
      o_merged = i_old_word;
      for (int k = 0; k < 4; k++) begin
         if (o_mask[k]) begin
            o_merged[8*k +: 8] = w_wrep[8*k +: 8];
         end else begin
            o_merged[8*k +: 8] = i_old_word[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_ws.sv
// dmem_ws: single-port data memory with byte/half/word access, programmable
// wait states and a req/ready handshake for the MIPS interrupt core.
// Optional macro DMEM_ADDR_ERR_EN adds the addr_err output; misaligned
// accesses then complete without writing and return zero. Without it,
// misaligned accesses are forced down to natural alignment.
module dmem_ws
   import dmem_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int DATA_W = 32,
   parameter int WAIT   = 1
) (
   input  logic              memclk,
   input  logic              clrn,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] datain,
   output logic [DATA_W-1:0] dataout,
   output logic              ready,
   output logic              busy
`ifdef DMEM_ADDR_ERR_EN
   ,
   output logic              addr_err
`endif
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] WAIT_LAST = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   dmem_op_t          r_op;
   logic [IDX_W+1:0]  r_addr;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_dataout;
   logic              r_ready;

   logic              w_idle;
   logic              w_accept;
   logic              w_commit;
   logic              w_write;
   dmem_op_t          w_op;
   logic [IDX_W+1:0]  w_addr;
   logic [IDX_W-1:0]  w_idx;
   logic [31:0]       w_old;
   logic [3:0]        w_mask;
   logic [31:0]       w_merged;
   logic [31:0]       w_load;
   logic [31:0]       w_result;
   logic              w_misalign;
   logic              w_unused;

   // Operand source: live inputs in IDLE (needed when WAIT=0), latched copy later.
   always_comb begin
      w_idle   = (r_state == ST_IDLE);
      w_accept = w_idle & req & clrn;
      if (w_idle) begin
         w_op   = '{we: we, size: size, sext: sext, wdata: datain};
         w_addr = addr[IDX_W+1:0];
      end else begin
         w_op   = r_op;
         w_addr = r_addr;
      end
      if (WAIT == 0) begin
         w_commit = w_accept;
      end else begin
         w_commit = (r_state == ST_WAIT) && (r_cnt == '0) && clrn;
      end
      w_idx = w_addr[IDX_W+1:2];
      w_old = r_mem[w_idx];
   end

   dmem_lane u_lane (
      .i_addr_lo  (w_addr[1:0]),
      .i_size     (w_op.size),
      .i_sext     (w_op.sext),
      .i_wdata    (w_op.wdata),
      .i_old_word (w_old),
      .o_mask     (w_mask),
      .o_merged   (w_merged),
      .o_load     (w_load),
      .o_misalign (w_misalign)
   );

   // Commit-cycle write enable and the value that dataout will capture.
   always_comb begin
`ifdef DMEM_ADDR_ERR_EN
      w_write = w_commit & w_op.we & ~w_misalign;
      if (w_misalign) begin
         w_result = 32'h0000_0000;
      end else if (w_op.we) begin
         w_result = w_merged;
      end else begin
         w_result = w_load;
      end
`else
      w_write = w_commit & w_op.we;
      if (w_op.we) begin
         w_result = w_merged;
      end else begin
         w_result = w_load;
      end
`endif
   end

   // Control FSM and completion outputs; reset abandons any pending access.
   always_ff @(posedge memclk) begin
      if (!clrn) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_op      <= '0;
         r_addr    <= '0;
         r_dataout <= '0;
         r_ready   <= 1'b0;
      end else begin
         r_ready <= w_commit;
         if (w_commit) begin
            r_dataout <= w_result;
         end
         case (r_state)
            ST_IDLE: begin
               if (req) begin
                  r_op    <= w_op;
                  r_addr  <= w_addr;
                  r_cnt   <= WAIT_LAST;
                  r_state <= (WAIT == 0) ? ST_DONE : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // RAM array: written on the edge that enters DONE, never cleared by reset.
   always_ff @(posedge memclk) begin
      if (w_write) begin
         r_mem[w_idx] <= w_merged;
      end
   end

`ifdef DMEM_ADDR_ERR_EN
   logic r_addr_err;

   // Address-error flag accompanies the ready pulse of a misaligned access.
   always_ff @(posedge memclk) begin
      if (!clrn) begin
         r_addr_err <= 1'b0;
      end else begin
         r_addr_err <= w_commit & w_misalign;
      end
   end

   assign addr_err = r_addr_err;
`endif

   assign dataout  = r_dataout;
   assign ready    = r_ready;
   // busy covers the accepting cycle itself through the DONE cycle.
   assign busy     = (r_state != ST_IDLE) | w_accept;
   assign w_unused = ^{addr[31:IDX_W+2], w_mask, w_misalign};

endmodule

// File: tb/tb_dmem_ws.sv
// tb_dmem_ws: table-driven check of dmem_ws (WAIT=1 instance) plus
// hand-written multi-cycle sequences on a WAIT=3 instance.
// Honors DMEM_ADDR_ERR_EN to choose misaligned-access expectations.
module tb_dmem_ws;
   import dmem_pkg::*;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_dout;
      logic        exp_err;
   } vec_t;

   localparam int NV = 22;

   logic        clk = 1'b0;
   logic        clrn, req1, req3, we, sext;
   logic [1:0]  size;
   logic [31:0] addr, datain;
   logic [31:0] dout1, dout3;
   logic        ready1, ready3, busy1, busy3;
`ifdef DMEM_ADDR_ERR_EN
   logic        err1, err3;
`endif
   int          n_tests = 0;
   int          n_fail  = 0;
   vec_t        vecs[NV];

   always #5 clk = ~clk;

   dmem_ws #(.DEPTH(32), .DATA_W(32), .WAIT(1)) u_dut1 (
      .memclk(clk), .clrn(clrn), .req(req1), .we(we), .size(size), .sext(sext),
      .addr(addr), .datain(datain), .dataout(dout1), .ready(ready1), .busy(busy1)
`ifdef DMEM_ADDR_ERR_EN
      , .addr_err(err1)
`endif
   );

   dmem_ws #(.DEPTH(32), .DATA_W(32), .WAIT(3)) u_dut3 (
      .memclk(clk), .clrn(clrn), .req(req3), .we(we), .size(size), .sext(sext),
      .addr(addr), .datain(datain), .dataout(dout3), .ready(ready3), .busy(busy3)
`ifdef DMEM_ADDR_ERR_EN
      , .addr_err(err3)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One WAIT=1 access: busy in acceptance cycle, ready exactly two cycles later.
   task automatic run1(input vec_t v, input string tag);
      @(negedge clk);
      we = v.we; size = v.size; sext = v.sext; addr = v.addr; datain = v.wdata;
      req1 = 1'b1;
      #1;
      chk({tag, "_busy_acc"}, 32'(busy1), 32'd1);
      @(posedge clk);
      #1;
      req1 = 1'b0;
      we = ~v.we; size = ~v.size; sext = ~v.sext; addr = ~v.addr; datain = ~v.wdata;
      @(negedge clk);
      chk({tag, "_ready_wait"}, 32'(ready1), 32'd0);
      chk({tag, "_busy_wait"}, 32'(busy1), 32'd1);
      @(negedge clk);
      chk({tag, "_ready_done"}, 32'(ready1), 32'd1);
      chk({tag, "_dout"}, dout1, v.exp_dout);
`ifdef DMEM_ADDR_ERR_EN
      chk({tag, "_addr_err"}, 32'(err1), 32'(v.exp_err));
`endif
      @(negedge clk);
      chk({tag, "_ready_after"}, 32'(ready1), 32'd0);
      chk({tag, "_busy_after"}, 32'(busy1), 32'd0);
      chk({tag, "_dout_hold"}, dout1, v.exp_dout);
   endtask

   // WAIT=3 store with a single-cycle request.
   task automatic run3_store(input logic [31:0] a, input logic [31:0] d);
      int seen;
      seen = 0;
      @(negedge clk);
      we = 1'b1; size = SZ_WORD; sext = 1'b0; addr = a; datain = d; req3 = 1'b1;
      @(posedge clk);
      #1;
      req3 = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (ready3) seen++;
      end
      chk("w3_store_ready", 32'(seen), 32'd1);
   endtask

   // WAIT=3 load with req held high until ready: one pulse, five busy cycles.
   task automatic run3_load(input logic [31:0] a, input logic [31:0] exp, input string tag);
      int nb, nr, rc;
      logic [31:0] dv;
      nb = 0; nr = 0; rc = -1; dv = 32'h0;
      @(negedge clk);
      we = 1'b0; size = SZ_WORD; sext = 1'b0; addr = a; datain = 32'h0; req3 = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (busy3) nb++;
         if (ready3) begin
            if (nr == 0) begin
               rc = c;
               dv = dout3;
            end
            nr++;
         end
         if (nr != 0) req3 = 1'b0;
         @(negedge clk);
      end
      req3 = 1'b0;
      chk({tag, "_busy_cycles"}, 32'(nb), 32'd5);
      chk({tag, "_ready_pulses"}, 32'(nr), 32'd1);
      chk({tag, "_latency"}, 32'(rc), 32'd4);
      chk({tag, "_dout"}, dv, exp);
   endtask

   initial begin
      #60000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int nr;
      vec_t v;
      clrn = 1'b0; req1 = 1'b0; req3 = 1'b0; we = 1'b0; size = 2'b00;
      sext = 1'b0; addr = 32'h0; datain = 32'h0;

      //             we    size     sext  addr      wdata          exp_dout      err
      vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h20, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h20, 32'h00000000, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11223344, 32'h11223344, 1'b0};
      vecs[3]  = '{1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h000000AA, 32'h1122AA44, 1'b0};
      vecs[4]  = '{1'b0, SZ_WORD, 1'b0, 32'h40, 32'h00000000, 32'h1122AA44, 1'b0};
      vecs[5]  = '{1'b0, SZ_BYTE, 1'b1, 32'h41, 32'h00000000, 32'hFFFFFFAA, 1'b0};
      vecs[6]  = '{1'b0, SZ_BYTE, 1'b0, 32'h41, 32'h00000000, 32'h000000AA, 1'b0};
      vecs[7]  = '{1'b1, SZ_WORD, 1'b0, 32'h44, 32'h12345678, 32'h12345678, 1'b0};
      vecs[8]  = '{1'b1, SZ_HALF, 1'b0, 32'h46, 32'hFFFF8001, 32'h80015678, 1'b0};
      vecs[9]  = '{1'b0, SZ_HALF, 1'b1, 32'h46, 32'h00000000, 32'hFFFF8001, 1'b0};
      vecs[10] = '{1'b0, SZ_HALF, 1'b0, 32'h46, 32'h00000000, 32'h00008001, 1'b0};
      vecs[11] = '{1'b0, SZ_WORD, 1'b0, 32'h44, 32'h00000000, 32'h80015678, 1'b0};
      vecs[12] = '{1'b1, SZ_WORD, 1'b0, 32'h80, 32'h00000005, 32'h00000005, 1'b0};
      vecs[13] = '{1'b0, SZ_WORD, 1'b0, 32'h00, 32'h00000000, 32'h00000005, 1'b0};
      vecs[14] = '{1'b0, SZ_BYTE, 1'b1, 32'h43, 32'h00000000, 32'h00000011, 1'b0};
      vecs[15] = '{1'b0, SZ_HALF, 1'b1, 32'h40, 32'h00000000, 32'hFFFFAA44, 1'b0};
      vecs[16] = '{1'b1, SZ_BYTE, 1'b0, 32'h23, 32'hFFFFFF7F, 32'h7FADBEEF, 1'b0};
      vecs[17] = '{1'b1, 2'b11,   1'b0, 32'h30, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
      vecs[18] = '{1'b0, 2'b11,   1'b0, 32'h30, 32'h00000000, 32'hCAFEF00D, 1'b0};
`ifdef DMEM_ADDR_ERR_EN
      vecs[19] = '{1'b0, SZ_HALF, 1'b1, 32'h47, 32'h00000000, 32'h00000000, 1'b1};
      vecs[20] = '{1'b1, SZ_WORD, 1'b0, 32'h22, 32'hA5A5A5A5, 32'h00000000, 1'b1};
      vecs[21] = '{1'b0, SZ_WORD, 1'b0, 32'h20, 32'h00000000, 32'h7FADBEEF, 1'b0};
`else
      vecs[19] = '{1'b0, SZ_HALF, 1'b1, 32'h47, 32'h00000000, 32'hFFFF8001, 1'b0};
      vecs[20] = '{1'b1, SZ_WORD, 1'b0, 32'h22, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
      vecs[21] = '{1'b0, SZ_WORD, 1'b0, 32'h20, 32'h00000000, 32'hA5A5A5A5, 1'b0};
`endif

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_dout1", dout1, 32'h0);
      chk("rst_ready1", 32'(ready1), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      chk("rst_dout3", dout3, 32'h0);
      chk("rst_ready3", 32'(ready3), 32'd0);
      chk("rst_busy3", 32'(busy3), 32'd0);
`ifdef DMEM_ADDR_ERR_EN
      chk("rst_err1", 32'(err1), 32'd0);
`endif
      clrn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run1(vecs[i], $sformatf("v%0d", i));
      end

      // Reset and request in the same cycle: request dropped, RAM kept.
      @(negedge clk);
      clrn = 1'b0; req1 = 1'b1; we = 1'b1; size = SZ_WORD; addr = 32'h0; datain = 32'h12121212;
      #1;
      chk("rstreq_busy", 32'(busy1), 32'd0);
      @(negedge clk);
      clrn = 1'b1; req1 = 1'b0;
      chk("rstreq_dout_cleared", dout1, 32'h0);
      nr = 0;
      repeat (4) begin
         @(negedge clk);
         if (ready1) nr++;
      end
      chk("rstreq_no_ready", 32'(nr), 32'd0);
      v = '{1'b0, SZ_WORD, 1'b0, 32'h00, 32'h00000000, 32'h00000005, 1'b0};
      run1(v, "rstreq_load");

      // WAIT=3: store, then load with req held every cycle.
      run3_store(32'h08, 32'h0BADF00D);
      run3_load(32'h08, 32'h0BADF00D, "w3a");

      // WAIT=3: reset during WAIT of a store abandons it.
      @(negedge clk);
      we = 1'b1; size = SZ_WORD; sext = 1'b0; addr = 32'h08; datain = 32'hFFFFFFFF; req3 = 1'b1;
      @(posedge clk);
      #1;
      req3 = 1'b0;
      @(negedge clk);
      chk("w3_busy_in_wait", 32'(busy3), 32'd1);
      clrn = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      chk("w3_rst_busy", 32'(busy3), 32'd0);
      chk("w3_rst_dout", dout3, 32'h0);
      nr = 0;
      repeat (8) begin
         @(negedge clk);
         if (ready3) nr++;
      end
      chk("w3_rst_no_ready", 32'(nr), 32'd0);
      run3_load(32'h08, 32'h0BADF00D, "w3b");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_ws.md
Name: dmem_ws

Overview:
- Parametrised data memory for the MIPS interrupt core: synchronous single-port SRAM model with byte/half/word access and configurable wait states.
- Uses a req/ready handshake so the pipeline can stall on memory.
- Successor to the fixed 32x32 word-only data RAM; adds sub-word stores, sign/zero-extended loads, latency control and reset.

Parameters:
- DEPTH, 32, number of DATA_W words; power of 2, at least 4.
- DATA_W, 32, word width in bits; fixed at 32 in this generation.
- WAIT, 1, extra wait cycles per access; range 0..7.

Ports:
- memclk  input  1  clock; all state changes on the rising edge.
- clrn  input  1  synchronous active-low reset.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- sext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  32  byte address.
- datain  input  32  store data, right-justified.
- dataout  output  32  load result, valid while ready=1.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high from acceptance until the cycle ready is high, inclusive.

Behaviour:
- Reset: when clrn=0 at a rising edge:
  - FSM goes to IDLE; ready=0, busy=0, dataout=0.
  - RAM contents are not cleared. They are zero at time 0.
- Word index is addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Byte order is little-endian: lane k is bits [8k+7:8k], selected by addr[1:0]. A half-word uses lanes addr[1]*2 and addr[1]*2+1.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if req=1, latch addr, we, size, sext and datain; set busy=1. Go to WAIT if WAIT>0, otherwise go to DONE.
  - WAIT: count down WAIT cycles; on the last one, go to DONE.
  - DONE: this is the commit cycle.
    - A store updates only the selected lanes.
    - A load registers the extracted and extended value into dataout.
    - ready=1 for exactly this cycle; return to IDLE.
- Latency: ready is high in cycle N+WAIT+1, where N is the acceptance cycle. Throughput is one access per WAIT+2 cycles.
- req while busy is ignored and not queued. Inputs may change freely after acceptance.
- Store completion: dataout shows the full post-write word for diagnostic use.
- dataout holds its last value between accesses.
- Load extension: a byte load with sext=1 and bit 7 set gives 0xFFFFFFxx. With sext=0, upper bits are zero. Half-word loads work the same way on bit 15.
- Misalignment when the feature is absent:
  - half with addr[0]=1 is forced down to an aligned half;
  - word with addr[1:0]!=0 is forced down to an aligned word.
- Reset mid-operation: a pending access is abandoned and no write occurs unless DONE was already committed.
- Reset and req in the same cycle: reset wins and the request is dropped.

Optional Feature:
- Macro DMEM_ADDR_ERR_EN.
- Defined:
  - Adds output addr_err (1 bit), reset to 0.
  - A misaligned access still runs the full handshake, but no RAM write occurs and dataout=0.
  - addr_err=1 in the same cycle as ready, feeding the CP0 address-error exception.
- Undefined: the port is absent and misaligned accesses use forced alignment as in Behaviour.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state encoding;
  - the wait-counter width constant (3 bits).
- Sub-module dmem_lane: combinational block that takes addr[1:0], size, sext, datain and the old word. It produces the lane write mask, the merged store word, the extended load value and the misalign flag.

Test Plan:
- WAIT=1; store word 0xDEADBEEF at 0x20, then load word at 0x20 -> ready two cycles after each acceptance; dataout=0xDEADBEEF.
- Word 0x11223344 at 0x40; store byte 0xAA at 0x41 -> word becomes 0x1122AA44. Load byte 0x41 with sext=1 -> 0xFFFFFFAA; with sext=0 -> 0x000000AA.
- Store half 0x8001 at 0x46; load half 0x46 with sext=1 -> 0xFFFF8001. Word at 0x44 -> 0x8001xxxx with lower half unchanged.
- DEPTH=32; store word 0x5 at 0x80 -> lands at index 0; load 0x00 returns 0x5 (wrap).
- Assert req on every cycle during a WAIT=3 load -> exactly one ready, busy high for 5 cycles. Assert clrn=0 in the WAIT state of a store -> RAM unchanged, ready never pulses.
- DMEM_ADDR_ERR_EN defined: store word at 0x22 -> ready=1 with addr_err=1, word at 0x20 unchanged. Undefined: the same store writes index 8.
